// File: rtl/ready_valid_to_axi_master.sv
// ready_valid_to_axi_master
// Single-outstanding AXI4-Lite master. Commands arrive on a ready/valid
// port, are issued on the AW/W or AR channel, and the B/R result is handed
// back on a ready/valid response port. One transaction in flight, in order.
//
// Handshake rule used on every channel here: a transfer happens on a rising
// edge where valid and ready are both high; a source holds valid and its
// payload stable until that edge and never withdraws valid early, and a sink
// may raise or drop ready freely.
module ready_valid_to_axi_master #(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 32
) (
    input  logic                                M00_AXI_aclk,
    input  logic                                M00_AXI_aresetn,
    // write address channel
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     M00_AXI_awaddr,
    output logic [2:0]                          M00_AXI_awprot,
    output logic                                M00_AXI_awvalid,
    input  logic                                M00_AXI_awready,
    // write data channel
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     M00_AXI_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   M00_AXI_wstrb,
    output logic                                M00_AXI_wvalid,
    input  logic                                M00_AXI_wready,
    // write response channel
    input  logic [1:0]                          M00_AXI_bresp,
    input  logic                                M00_AXI_bvalid,
    output logic                                M00_AXI_bready,
    // read address channel
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     M00_AXI_araddr,
    output logic [2:0]                          M00_AXI_arprot,
    output logic                                M00_AXI_arvalid,
    input  logic                                M00_AXI_arready,
    // read data channel
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     M00_AXI_rdata,
    input  logic [1:0]                          M00_AXI_rresp,
    input  logic                                M00_AXI_rvalid,
    output logic                                M00_AXI_rready,
    // command port
    input  logic                                cmd_valid_i,
    output logic                                cmd_ready_o,
    input  logic                                cmd_write_i,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata_i,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb_i,
    // response port
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic                                rsp_write_o,
    output logic [1:0]                          rsp_resp_o,
    output logic                                rsp_error_o,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata_o,
    // FSM state, exposed for debug and checkers
    output logic [2:0]                          state_dbg_o
);

    localparam int DW = C_M00_AXI_DATA_WIDTH;
    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int SW = C_M00_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_WAIT_B = 3'd2,
        S_READ   = 3'd3,
        S_WAIT_R = 3'd4,
        S_RESP   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            write_q, write_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [1:0]      resp_q, resp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    // Goes high on the first edge after reset release so cmd_ready_o stays
    // low while reset is asserted even though the state register sits in IDLE.
    logic            live_q;

    logic            aw_valid;
    logic            w_valid;
    logic            cmd_ready;

    // Channel valids are pure functions of registered state: no path from
    // cmd_valid_i or rsp_ready_i reaches any AXI output or cmd_ready_o.
    always_comb begin
        cmd_ready = live_q && (state_q == S_IDLE);
        aw_valid  = (state_q == S_WRITE) && !aw_done_q;
        w_valid   = (state_q == S_WRITE) && !w_done_q;
    end

    // Next-state logic: latch the command, track AW/W completion
    // independently, capture the B or R result, hold it until consumed.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready) begin
                    addr_d    = cmd_addr_i;
                    wdata_d   = cmd_wdata_i;
                    wstrb_d   = cmd_wstrb_i;
                    write_d   = cmd_write_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write_i ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (aw_valid && M00_AXI_awready) aw_done_d = 1'b1;
                if (w_valid && M00_AXI_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)       state_d   = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (M00_AXI_bvalid) begin
                    resp_d  = M00_AXI_bresp;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
            end
            S_READ: begin
                if (M00_AXI_arready) state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (M00_AXI_rvalid) begin
                    resp_d  = M00_AXI_rresp;
                    rdata_d = M00_AXI_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction at once.
    always_ff @(posedge M00_AXI_aclk or negedge M00_AXI_aresetn) begin
        if (!M00_AXI_aresetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= 2'b00;
            rdata_q   <= '0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            live_q    <= 1'b1;
        end
    end

    // Output mapping straight from registered state.
    always_comb begin
        M00_AXI_awaddr  = addr_q;
        M00_AXI_awprot  = 3'b000;
        M00_AXI_awvalid = aw_valid;
        M00_AXI_wdata   = wdata_q;
        M00_AXI_wstrb   = wstrb_q;
        M00_AXI_wvalid  = w_valid;
        M00_AXI_bready  = (state_q == S_WAIT_B);
        M00_AXI_araddr  = addr_q;
        M00_AXI_arprot  = 3'b000;
        M00_AXI_arvalid = (state_q == S_READ);
        M00_AXI_rready  = (state_q == S_WAIT_R);
        cmd_ready_o     = cmd_ready;
        rsp_valid_o     = (state_q == S_RESP);
        rsp_write_o     = write_q;
        rsp_resp_o      = resp_q;
        rsp_error_o     = (resp_q != 2'b00);
        rsp_rdata_o     = rdata_q;
        state_dbg_o     = state_q;
    end

endmodule

// File: tb/tb_ready_valid_to_axi_master.sv
// Testbench for ready_valid_to_axi_master: directed timing vectors, reset
// cases, and a random in-order stream against an AXI-lite slave model.
`timescale 1ns/1ps
module tb_ready_valid_to_axi_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0] awaddr, wdata, araddr, rdata, cmd_addr, cmd_wdata, rsp_rdata;
  logic [2:0]  awprot, arprot, state_dbg;
  logic [3:0]  wstrb, cmd_wstrb;
  logic [1:0]  bresp, rresp, rsp_resp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic cmd_valid, cmd_ready, cmd_write;
  logic rsp_valid, rsp_ready, rsp_write, rsp_error;

  ready_valid_to_axi_master #(
    .C_M00_AXI_DATA_WIDTH(32),
    .C_M00_AXI_ADDR_WIDTH(32)
  ) dut (
    .M00_AXI_aclk(clk), .M00_AXI_aresetn(rst_n),
    .M00_AXI_awaddr(awaddr), .M00_AXI_awprot(awprot), .M00_AXI_awvalid(awvalid), .M00_AXI_awready(awready),
    .M00_AXI_wdata(wdata), .M00_AXI_wstrb(wstrb), .M00_AXI_wvalid(wvalid), .M00_AXI_wready(wready),
    .M00_AXI_bresp(bresp), .M00_AXI_bvalid(bvalid), .M00_AXI_bready(bready),
    .M00_AXI_araddr(araddr), .M00_AXI_arprot(arprot), .M00_AXI_arvalid(arvalid), .M00_AXI_arready(arready),
    .M00_AXI_rdata(rdata), .M00_AXI_rresp(rresp), .M00_AXI_rvalid(rvalid), .M00_AXI_rready(rready),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
    .rsp_resp_o(rsp_resp), .rsp_error_o(rsp_error), .rsp_rdata_o(rsp_rdata),
    .state_dbg_o(state_dbg)
  );

  // ---------------- shared bench state ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          d0;   // AW / AR ready delay
    int          d1;   // W ready delay
    int          d2;   // B delay after AW+W, or R wait cycles
    logic [1:0]  resp;
  } cfg_t;

  cfg_t        cfg_q[$];
  logic [35:0] exp_q[$];          // {write, resp, error, rdata}
  logic [31:0] shadow [16];       // expected memory contents
  logic [31:0] slv_mem [16];      // slave model memory
  int checks = 0;
  int failures = 0;
  logic rsp_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic cfg_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int d0, input int d1, input int d2,
                              input logic [1:0] resp);
    cfg_t c;
    c.wr = wr; c.addr = a; c.wdata = d; c.strb = s;
    c.d0 = d0; c.d1 = d1; c.d2 = d2; c.resp = resp;
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  // Queue the slave behaviour and expected response, then offer the command.
  task automatic start_cmd(input cfg_t c);
    logic [3:0] idx;
    idx = c.addr[5:2];
    cfg_q.push_back(c);
    if (c.wr) begin
      shadow[idx] = merge(shadow[idx], c.wdata, c.strb);
      exp_q.push_back({1'b1, c.resp, (c.resp != 2'b00), 32'h0});
    end else begin
      exp_q.push_back({1'b0, c.resp, (c.resp != 2'b00), shadow[idx]});
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = c.wr;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    cmd_wstrb = c.strb;
  endtask

  // Returns on the negedge of the cycle after the command handshake.
  task automatic wait_accept();
    int n;
    n = 0;
    #1;
    while (!cmd_ready && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: cmd_ready=%0b required 1 after %0d cycles", cmd_ready, n);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic issue(input cfg_t c);
    start_cmd(c);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- response ready driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_rand) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- AXI-lite slave model ----------------
  cfg_t        sc;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic        aborted;

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (rst_n && (awvalid || arvalid)) begin
        if (cfg_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL slave_no_cfg: unexpected request at %0t", $time);
        end else begin
          sc = cfg_q.pop_front();
          if (awvalid) begin
            fork
              begin
                repeat (sc.d0) @(negedge clk);
                awready = 1; cap_awaddr = awaddr;
                @(negedge clk);
                awready = 0;
              end
              begin
                repeat (sc.d1) @(negedge clk);
                wready = 1; cap_wdata = wdata; cap_wstrb = wstrb;
                @(negedge clk);
                wready = 0;
              end
            join
            check("slv_awaddr", cap_awaddr, sc.addr);
            check("slv_wdata", {cap_wstrb, cap_wdata}, {sc.strb, sc.wdata});
            slv_mem[cap_awaddr[5:2]] = merge(slv_mem[cap_awaddr[5:2]], cap_wdata, cap_wstrb);
            repeat (sc.d2) @(negedge clk);
            bvalid = 1; bresp = sc.resp;
            check("slv_bready", bready, 1);
            @(negedge clk);
            bvalid = 0; bresp = 0;
          end else begin
            repeat (sc.d0) @(negedge clk);
            arready = 1; cap_araddr = araddr;
            @(negedge clk);
            arready = 0;
            check("slv_araddr", cap_araddr, sc.addr);
            aborted = 0;
            for (int i = 0; i < sc.d2; i++) begin
              @(negedge clk);
              if (!rst_n) begin
                aborted = 1;
                break;
              end
            end
            if (!aborted) begin
              rvalid = 1; rdata = slv_mem[cap_araddr[5:2]]; rresp = sc.resp;
              check("slv_rready", rready, 1);
              @(negedge clk);
              rvalid = 0; rdata = 0; rresp = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [35:0] exp_v;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected: response 0x%0h with empty queue", {rsp_write, rsp_resp, rsp_error, rsp_rdata});
        end else begin
          exp_v = exp_q.pop_front();
          check("rsp", {rsp_write, rsp_resp, rsp_error, rsp_rdata}, exp_v);
        end
      end
    end
  end

  // ---------------- hold-stable monitor ----------------
  logic pv_aw = 0, pr_aw = 0, pv_w = 0, pr_w = 0, pv_ar = 0, pr_ar = 0, pv_rsp = 0, pr_rsp = 0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  logic [35:0] p_rsp;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        pv_aw = 0; pv_w = 0; pv_ar = 0; pv_rsp = 0;
      end else begin
        if (pv_aw && !pr_aw)   check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (pv_w && !pr_w)     check("w_hold", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
        if (pv_ar && !pr_ar)   check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
        if (pv_rsp && !pr_rsp) check("rsp_hold", {rsp_valid, rsp_write, rsp_resp, rsp_error, rsp_rdata}, {1'b1, p_rsp});
        pv_aw = awvalid; pr_aw = awready; p_awaddr = awaddr;
        pv_w = wvalid; pr_w = wready; p_wdata = wdata; p_wstrb = wstrb;
        pv_ar = arvalid; pr_ar = arready; p_araddr = araddr;
        pv_rsp = rsp_valid; pr_rsp = rsp_ready; p_rsp = {rsp_write, rsp_resp, rsp_error, rsp_rdata};
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 0);
    check({tag, "_addr"}, {awaddr, araddr}, 0);
    check({tag, "_wdata"}, {wstrb, wdata, awprot, arprot}, 0);
    check({tag, "_rsp"}, {rsp_write, rsp_resp, rsp_error, rsp_rdata}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 1;
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 32'h0;
      slv_mem[i] = 32'h0;
    end

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1;
    step();
    check("ready_after_release", cmd_ready, 1);

    // best-case write: 4-cycle issue-to-issue
    issue(mk(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00));
    #1;
    check("w1_c1_valids", {awvalid, wvalid, awaddr, wdata, wstrb}, {1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF});
    check("w1_c1_cmd_ready", cmd_ready, 0);
    step();
    check("w1_c2", {awvalid, wvalid, bready}, 3'b001);
    step();
    check("w1_c3", {rsp_valid, bready, cmd_ready}, 3'b100);
    step();
    check("w1_c4", {cmd_ready, rsp_valid}, 2'b10);

    // AW delayed 3, W immediate
    issue(mk(1, 32'h8, 32'hA5A5_0001, 4'hF, 3, 0, 0, 2'b00));
    #1;
    check("awd_c1", {awvalid, wvalid}, 2'b11);
    step();
    check("awd_c2", {awvalid, wvalid, bready}, 3'b100);
    step(); step();
    check("awd_c4", {awvalid, wvalid, bready}, 3'b100);
    step();
    check("awd_c5", {awvalid, wvalid, bready}, 3'b001);
    drain();

    // W delayed 3, AW immediate (mirror image)
    issue(mk(1, 32'h10, 32'h5A5A_0002, 4'hF, 0, 3, 0, 2'b01));
    #1;
    check("wd_c1", {awvalid, wvalid}, 2'b11);
    step();
    check("wd_c2", {awvalid, wvalid, bready}, 3'b010);
    step(); step();
    check("wd_c4", {awvalid, wvalid, bready}, 3'b010);
    step();
    check("wd_c5", {awvalid, wvalid, bready}, 3'b001);
    drain();

    // read from 0xC after seeding it; two R wait cycles, rresp SLVERR
    issue(mk(1, 32'hC, 32'h12345678, 4'hF, 0, 0, 0, 2'b00));
    drain();
    issue(mk(0, 32'hC, 32'h0, 4'h0, 0, 0, 2, 2'b10));
    #1;
    check("r_c1", {arvalid, araddr, rready}, {1'b1, 32'hC, 1'b0});
    step();
    check("r_c2", {arvalid, rready}, 2'b01);
    step(); step();
    check("r_c4", {rready, rsp_valid}, 2'b10);
    step();
    check("r_c5", {rready, rsp_valid, rsp_rdata, rsp_resp, rsp_error},
          {1'b0, 1'b1, 32'h12345678, 2'b10, 1'b1});
    drain();

    // partial strobe write then read back the merged word
    issue(mk(1, 32'h4, 32'h0000AA00, 4'b0010, 1, 2, 1, 2'b00));
    issue(mk(0, 32'h4, 32'h0, 4'h0, 1, 0, 1, 2'b00));
    drain();

    // response held off for 5 cycles; a new command must wait
    rsp_ready = 0;
    issue(mk(1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00));
    step(); step();
    check("hold_c3", {rsp_valid, cmd_ready}, 2'b10);
    start_cmd(mk(1, 32'h24, 32'h0BAD_BEEF, 4'hF, 0, 0, 0, 2'b00));
    #1;
    for (int i = 0; i < 4; i++) begin
      check("hold_stall", {rsp_valid, cmd_ready, awvalid}, 3'b100);
      step();
    end
    rsp_ready = 1;
    #1;
    check("hold_release", {rsp_valid, cmd_ready}, 2'b10);
    step();
    check("hold_accept_cycle", {cmd_ready, rsp_valid}, 2'b10);
    wait_accept();
    #1;
    check("hold_next_issued", {cmd_ready, awvalid, awaddr}, {1'b0, 1'b1, 32'h24});
    drain();

    // reset pulsed while waiting for R
    issue(mk(0, 32'h8, 32'h0, 4'h0, 0, 0, 20, 2'b00));
    step();
    check("rst_wait_r", rready, 1);
    step();
    #1;
    rst_n = 0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    cfg_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
    check("midreset_ready", cmd_ready, 1);
    issue(mk(0, 32'h8, 32'h0, 4'h0, 1, 0, 1, 2'b00));
    drain();

    // random in-order stream with random stalls and response backpressure
    rsp_rand = 1;
    for (int n = 0; n < 1000; n++) begin
      logic [1:0] r;
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      issue(mk(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r));
    end
    drain();
    rsp_rand = 0;
    rsp_ready = 1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
